// File: rtl/apb_cmd_arbiter_if.sv
// Requester, bridge-command and APB-monitor bundle for apb_cmd_arbiter.
// slave = arbiter side, master = requesters/bridge/bus side.
interface apb_cmd_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int CMD_W  = 56,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]       req_i;
  logic [NREQ*CMD_W-1:0] cmd_i;
  logic [NREQ-1:0]       gnt_o;
  logic [NREQ-1:0]       ack_o;
  logic [DATA_W-1:0]     rd_data_o;
  logic                  slverr_o;
  logic                  busy_o;
  logic [CMD_W-1:0]      cmd_o;
  logic                  cmd_vld_o;
  logic [DATA_W-1:0]     cmd_rd_data_i;
  logic                  psel_i;
  logic                  penable_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport slave (
    input  req_i, cmd_i, cmd_rd_data_i,
    input  psel_i, penable_i, pready_i, pslverr_i,
    output gnt_o, ack_o, rd_data_o, slverr_o,
    output busy_o, cmd_o, cmd_vld_o
  );

  modport master (
    output req_i, cmd_i, cmd_rd_data_i,
    output psel_i, penable_i, pready_i, pslverr_i,
    input  gnt_o, ack_o, rd_data_o, slverr_o,
    input  busy_o, cmd_o, cmd_vld_o
  );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// Round-robin sharing of one APB bridge command port, one transfer in flight.
// Optional APB_ARB_HIPRI_EN: requester 0 wins every arbitration it joins.
module apb_cmd_arbiter #(
  parameter int NREQ   = 4,
  parameter int CMD_W  = 56,
  parameter int DATA_W = 32
) (
  input  logic            pclk_i,
  input  logic            prst_n_i,
  apb_cmd_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_own;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [CMD_W-1:0]  r_cmd;
  logic              r_vld;
  logic              r_busy;
  logic              r_slverr;
  logic [DATA_W-1:0] r_rdata;

  logic [PW:0]       w_k;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_nxt;
  logic              w_found;
  logic              w_hs;
  logic              w_rd;

  assign w_hs = bus.psel_i & bus.penable_i & bus.pready_i;
  assign w_rd = (r_cmd[CMD_W-1 -: 8] == 8'h00);
  assign w_nxt = (r_own == PW'(NREQ-1)) ? '0 : r_own + 1'b1;

  // First requesting index at or after r_ptr, wrapping.
  always_comb begin
    w_k     = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_k >= (PW+1)'(NREQ))
        w_k = w_k - (PW+1)'(NREQ);
      if (!w_found && bus.req_i[w_k[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_k[PW-1:0];
      end
    end
`ifdef APB_ARB_HIPRI_EN
    if (bus.req_i[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_own    <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_cmd    <= '0;
      r_vld    <= 1'b0;
      r_busy   <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_ISSUE;
            r_own   <= w_win;
            r_gnt   <= NREQ'(1) << w_win;
            r_cmd   <= bus.cmd_i[w_win*CMD_W +: CMD_W];
            r_vld   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_vld   <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_hs) begin
            r_state  <= S_DONE;
            r_ack    <= r_gnt;
            r_slverr <= bus.pslverr_i;
            if (w_rd)
              r_rdata <= bus.cmd_rd_data_i;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ack   <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
`ifdef APB_ARB_HIPRI_EN
          // Requester 0 bypasses the rotation, so it must not move it.
          if (r_own != '0)
            r_ptr <= w_nxt;
`else
          r_ptr <= w_nxt;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.ack_o     = r_ack;
  assign bus.rd_data_o = r_rdata;
  assign bus.slverr_o  = r_slverr;
  assign bus.busy_o    = r_busy;
  assign bus.cmd_o     = r_cmd;
  assign bus.cmd_vld_o = r_vld;
endmodule
